// File: rtl/mem_read_responder.sv
// mem_read_responder
// Backing-store responder for the program-memory read channel. Holds a
// 2^ADDR_BITS x DATA_BITS word array, answers each accepted read with a
// one-cycle read_ready pulse LATENCY edges after acceptance, and offers a
// side load port for the host to write program words at any time.
//
// Optional feature: define MEM_RESP_STATS_EN to add the saturating
// req_count / wait_count activity outputs.
module mem_read_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int LATENCY      = 1,   // 1..15
    parameter int INIT_PATTERN = 1    // 1: word i starts as (i*2+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    output logic                 read_ready,
    output logic [DATA_BITS-1:0] read_data,
    input  logic                 load_valid,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [DATA_BITS-1:0] load_data,
    output logic                 busy
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0]          req_count,
    output logic [15:0]          wait_count
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef logic [DEPTH-1:0][DATA_BITS-1:0] mem_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Power-up image of the array: odd-number ramp, or don't-care.
    function automatic mem_t init_mem();
        mem_t m;
        m = 'x;
        if (INIT_PATTERN != 0) begin
            for (int i = 0; i < DEPTH; i++) begin
                m[ADDR_BITS'(i)] = DATA_BITS'(i * 2 + 1);
            end
        end
        return m;
    endfunction

    mem_t                 mem = init_mem();
    state_t               state;
    logic [3:0]           lat_cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_en;

    // Loads are ignored while reset is asserted.
    assign write_en = load_valid && reset;

    // Side load port: one word per edge, never stalls.
    // NOTE: the array is deliberately left out of reset so program contents
    // survive a reset and the storage can map onto plain RAM/flops without a
    // clear path.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[load_address] <= load_data;
        end
    end

    // Request FSM: accept in IDLE, count down in WAIT, pulse in RESPOND.
    // NOTE: all state here uses non-blocking assignments, so the array read
    // taken on the responding edge sees the word as it was before any load on
    // that same edge (read-before-write).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            addr_q     <= '0;
            read_ready <= 1'b0;
            read_data  <= '0;
            busy       <= 1'b0;
        end else begin
            read_ready <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (read_valid) begin
                        addr_q  <= read_address;
                        lat_cnt <= LAT_LOAD;
                        busy    <= 1'b1;
                        if (LATENCY == 1) begin
                            state      <= ST_RESPOND;
                            read_ready <= 1'b1;
                            read_data  <= mem[read_address];
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state      <= ST_RESPOND;
                        read_ready <= 1'b1;
                        read_data  <= mem[addr_q];
                    end
                end
                ST_RESPOND: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_RESP_STATS_EN
    // Saturating counters of accepted requests and cycles spent waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_count  <= '0;
            wait_count <= '0;
        end else begin
            if (state == ST_IDLE && read_valid && req_count != 16'hFFFF) begin
                req_count <= req_count + 16'd1;
            end
            if (state == ST_WAIT && wait_count != 16'hFFFF) begin
                wait_count <= wait_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: a LATENCY=1 and a LATENCY=3 instance share
// clock, reset and the load port. Expected words come from a bench-side
// memory image and are queued per instance together with the cycle on which
// the read_ready pulse is due; monitors pop and compare on every pulse.
module tb_mem_read_responder;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rv1 = 1'b0, rv3 = 1'b0;
    logic [7:0]  ra1 = '0,   ra3 = '0;
    logic        rr1, rr3;
    logic [15:0] rd1, rd3;
    logic        busy1, busy3;
    logic        load_valid = 1'b0;
    logic [7:0]  load_address = '0;
    logic [15:0] load_data = '0;
`ifdef MEM_RESP_STATS_EN
    logic [15:0] rc1, wc1, rc3, wc3;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_req3 = 0;
    logic [15:0] model [256];
    exp_t sb1[$];
    exp_t sb3[$];
    exp_t e1, e3;

    mem_read_responder #(.ADDR_BITS(8), .DATA_BITS(16), .LATENCY(1), .INIT_PATTERN(1)) u_l1 (
        .clk(clk), .reset(reset),
        .read_valid(rv1), .read_address(ra1), .read_ready(rr1), .read_data(rd1),
        .load_valid(load_valid), .load_address(load_address), .load_data(load_data),
        .busy(busy1)
`ifdef MEM_RESP_STATS_EN
        , .req_count(rc1), .wait_count(wc1)
`endif
    );

    mem_read_responder #(.ADDR_BITS(8), .DATA_BITS(16), .LATENCY(3), .INIT_PATTERN(1)) u_l3 (
        .clk(clk), .reset(reset),
        .read_valid(rv3), .read_address(ra3), .read_ready(rr3), .read_data(rd3),
        .load_valid(load_valid), .load_address(load_address), .load_data(load_data),
        .busy(busy3)
`ifdef MEM_RESP_STATS_EN
        , .req_count(rc3), .wait_count(wc3)
`endif
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp acceptances and pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor for the LATENCY=1 instance.
    always @(negedge clk) begin
        if (rr1) begin
            if (sb1.size() == 0) begin
                check("l1_spurious_ready", 32'(rr1), 32'd0);
            end else begin
                e1 = sb1.pop_front();
                check("l1_data", 32'(rd1), 32'(e1.data));
                check("l1_pulse_cycle", cyc, e1.due);
            end
        end else if (sb1.size() != 0 && sb1[0].due < cyc) begin
            e1 = sb1.pop_front();
            check("l1_missing_ready", 32'(rr1), 32'd1);
        end
    end

    // Monitor for the LATENCY=3 instance.
    always @(negedge clk) begin
        if (rr3) begin
            if (sb3.size() == 0) begin
                check("l3_spurious_ready", 32'(rr3), 32'd0);
            end else begin
                e3 = sb3.pop_front();
                check("l3_data", 32'(rd3), 32'(e3.data));
                check("l3_pulse_cycle", cyc, e3.due);
            end
        end else if (sb3.size() != 0 && sb3[0].due < cyc) begin
            e3 = sb3.pop_front();
            check("l3_missing_ready", 32'(rr3), 32'd1);
        end
    end

    // One LATENCY=1 read; called and returns at a negedge with the DUT idle.
    task automatic req1(input logic [7:0] addr);
        rv1 = 1'b1;
        ra1 = addr;
        sb1.push_back('{data: model[addr], due: cyc + 1});
        @(negedge clk);
        rv1 = 1'b0;
        check("l1_busy_respond", 32'(busy1), 32'd1);
        @(negedge clk);
        check("l1_busy_idle", 32'(busy1), 32'd0);
    endtask

    // One LATENCY=3 read; the address is moved to 0x00 while busy.
    task automatic req3(input logic [7:0] addr);
        rv3 = 1'b1;
        ra3 = addr;
        sb3.push_back('{data: model[addr], due: cyc + 3});
        n_req3++;
        @(negedge clk);
        rv3 = 1'b0;
        ra3 = 8'h00;
        check("l3_busy_wait", 32'(busy3), 32'd1);
        repeat (2) @(negedge clk);
        check("l3_busy_respond", 32'(busy3), 32'd1);
        @(negedge clk);
        check("l3_busy_idle", 32'(busy3), 32'd0);
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] data);
        load_valid   = 1'b1;
        load_address = addr;
        load_data    = data;
        @(negedge clk);
        load_valid = 1'b0;
        model[addr] = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 16'(i * 2 + 1);

        // Reset state, held across two rising edges.
        repeat (2) @(negedge clk);
        check("rst_ready", {30'd0, rr1, rr3}, 32'd0);
        check("rst_data1", 32'(rd1), 32'd0);
        check("rst_data3", 32'(rd3), 32'd0);
        check("rst_busy", {30'd0, busy1, busy3}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic LATENCY=1 read, then a few random addresses.
        req1(8'h05);
        for (int i = 0; i < 4; i++) req1(8'($urandom_range(0, 255)));

        // Back-to-back with read_valid held: pulses two cycles apart.
        rv1 = 1'b1;
        ra1 = 8'h02;
        sb1.push_back('{data: model[8'h02], due: cyc + 1});
        @(negedge clk);
        ra1 = 8'h03;
        sb1.push_back('{data: model[8'h03], due: cyc + 2});
        repeat (2) @(negedge clk);
        rv1 = 1'b0;
        @(negedge clk);

        // LATENCY=3 read of the top address.
        req3(8'hFF);
        req3(8'h40);

        // Load then read back on both instances.
        load(8'h10, 16'h1234);
        req1(8'h10);
        req3(8'h10);

        // Load landing on the responding edge: old word returned, new word next.
        rv3 = 1'b1;
        ra3 = 8'h20;
        sb3.push_back('{data: model[8'h20], due: cyc + 3});
        @(negedge clk);
        rv3 = 1'b0;
        @(negedge clk);
        load_valid   = 1'b1;
        load_address = 8'h20;
        load_data    = 16'hBEEF;
        @(negedge clk);
        load_valid = 1'b0;
        model[8'h20] = 16'hBEEF;
        @(negedge clk);
        req3(8'h20);
        req1(8'h20);

        // Reset while the LATENCY=3 instance is in WAIT.
        rv3 = 1'b1;
        ra3 = 8'h07;
        sb3.push_back('{data: model[8'h07], due: cyc + 3});
        @(negedge clk);
        rv3 = 1'b0;
        reset = 1'b0;
        sb3.delete();
        n_req3 = 0;
        #1;
        check("midrst_ready3", 32'(rr3), 32'd0);
        check("midrst_data3", 32'(rd3), 32'd0);
        check("midrst_busy3", 32'(busy3), 32'd0);
        check("midrst_data1", 32'(rd1), 32'd0);
        // A load during reset must not land.
        load_valid   = 1'b1;
        load_address = 8'h30;
        load_data    = 16'hDEAD;
        @(negedge clk);
        load_valid = 1'b0;
        reset = 1'b1;
        repeat (6) @(negedge clk);
        req3(8'h30);
        req1(8'h30);

`ifdef MEM_RESP_STATS_EN
        reset = 1'b0;
        n_req3 = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) req3(8'(i * 7));
        check("stats_req_count", 32'(rc3), 32'(n_req3));
        check("stats_wait_count", 32'(wc3), 32'(n_req3 * 2));
`endif

        repeat (4) @(negedge clk);
        check("sb1_drained", sb1.size(), 0);
        check("sb3_drained", sb3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
